// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Brief    : Board-reset synchroniser and staggered per-channel reset release
//            with masked soft-reset replay.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYC    = 10,
    parameter int STAGGER_CYC = 3,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_req,
    input  logic [CHANNELS-1:0] ch_mask,
    output logic [CHANNELS-1:0] rst_out,
    output logic                done,
    output logic                busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]    STAG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] CH_ONE    = CHANNELS'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t              r_state,   w_state_nx;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nx;
    logic [IDX_W-1:0]    r_idx,     w_idx_nx;
    logic [CHANNELS-1:0] r_mask,    w_mask_nx;
    logic [CHANNELS-1:0] r_rst_out, w_rst_out_nx;
    logic                r_done,    w_done_nx;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_soft_prev;
    logic                w_soft_hit;
    logic [CHANNELS-1:0] w_rel_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_soft_prev <= 1'b0;
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_mask      <= '0;
            r_rst_out   <= '1;
            r_done      <= 1'b0;
        end else begin
            r_sync1     <= 1'b1;
            r_sync2     <= r_sync1;
            r_soft_prev <= soft_req;
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_mask      <= w_mask_nx;
            r_rst_out   <= w_rst_out_nx;
            r_done      <= w_done_nx;
        end
    end

    // Only a fresh rising edge of soft_req seen while idle restarts the schedule.
    assign w_soft_hit = (r_state == ST_RUN) && soft_req && !r_soft_prev;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_idx_nx     = r_idx;
        w_mask_nx    = r_mask;
        w_rst_out_nx = r_rst_out;
        w_done_nx    = r_done;
        w_rel_vec    = '0;

        case (r_state)
            ST_HOLD: begin
                if (r_sync2) begin
                    if (r_cnt == HOLD_LAST) begin
                        w_rel_vec = CH_ONE;
                        w_cnt_nx  = '0;
                        if (CHANNELS == 1) begin
                            w_state_nx = ST_RUN;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx = ST_STAGGER;
                            w_idx_nx   = IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            ST_STAGGER: begin
                if (r_cnt == STAG_LAST) begin
                    w_rel_vec = CH_ONE << r_idx;
                    w_cnt_nx  = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = ST_RUN;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_soft_hit) begin
                    w_state_nx   = ST_HOLD;
                    w_cnt_nx     = '0;
                    w_idx_nx     = '0;
                    w_done_nx    = 1'b0;
                    w_mask_nx    = ch_mask;
                    w_rst_out_nx = ~ch_mask;
                end
            end
            default: begin
                w_state_nx = ST_HOLD;
                w_cnt_nx   = '0;
                w_idx_nx   = '0;
            end
        endcase

        // Masked channels are held released for the whole replay.
        if (r_state != ST_RUN) begin
            w_rst_out_nx = r_rst_out & ~w_rel_vec & ~r_mask;
        end
    end

    assign rst_out = r_rst_out;
    assign done    = r_done;
    assign busy    = ~r_done;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Directed self-checking bench for reset_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration instance
    logic       rst0 = 1'b0;
    logic       soft0 = 1'b0;
    logic [3:0] mask0 = 4'b0000;
    logic [3:0] rst_out0;
    logic       done0, busy0;

    // CHANNELS=1, HOLD_CYC=1 instance
    logic       rst1 = 1'b0;
    logic       soft1 = 1'b0;
    logic [0:0] mask1 = 1'b0;
    logic [0:0] rst_out1;
    logic       done1, busy1;

    // CHANNELS=8, STAGGER_CYC=1 instance
    logic       rst2 = 1'b0;
    logic       soft2 = 1'b0;
    logic [7:0] mask2 = 8'h00;
    logic [7:0] rst_out2;
    logic       done2, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    reset_sequencer #(.CHANNELS(4), .HOLD_CYC(10), .STAGGER_CYC(3), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst0), .soft_req(soft0), .ch_mask(mask0),
        .rst_out(rst_out0), .done(done0), .busy(busy0)
    );

    reset_sequencer #(.CHANNELS(1), .HOLD_CYC(1), .STAGGER_CYC(3), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst1), .soft_req(soft1), .ch_mask(mask1),
        .rst_out(rst_out1), .done(done1), .busy(busy1)
    );

    reset_sequencer #(.CHANNELS(8), .HOLD_CYC(10), .STAGGER_CYC(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst2), .soft_req(soft2), .ch_mask(mask2),
        .rst_out(rst_out2), .done(done2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #23;
        n_cmp++;
        if (rst_out0 !== 4'b1111 || done0 !== 1'b0 || busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: rst_out=%b done=%b busy=%b, expected 1111/0/1",
                     rst_out0, done0, busy0);
        end
    endtask

    task automatic test_power_on();
        int rel[4] = '{10, 13, 16, 19};
        logic [3:0] exp_out;
        logic       exp_done;
        repeat (10) @(negedge clk);
        rst0 = 1'b1;
        step();
        step();
        for (int n = 0; n <= 22; n++) begin
            if (n > 0) step();
            for (int i = 0; i < 4; i++) exp_out[i] = (n < rel[i]);
            exp_done = (n >= 19);
            n_cmp++;
            if (rst_out0 !== exp_out || done0 !== exp_done || busy0 !== ~exp_done) begin
                n_bad++;
                $display("FAIL power_on E0+%0d: rst_out=%b done=%b busy=%b, expected %b/%b/%b",
                         n, rst_out0, done0, busy0, exp_out, exp_done, ~exp_done);
            end
        end
    endtask

    task automatic test_soft_mask();
        int rel[4] = '{10, 13, 16, 19};
        logic [3:0] exp_out;
        logic       exp_done;
        soft0 = 1'b1;
        mask0 = 4'b0101;
        step();
        soft0 = 1'b0;
        mask0 = 4'b0000;
        for (int n = 0; n <= 22; n++) begin
            if (n > 0) step();
            exp_out = 4'b1010;
            for (int i = 0; i < 4; i++) if (n >= rel[i]) exp_out[i] = 1'b0;
            exp_done = (n >= 19);
            n_cmp++;
            if (rst_out0 !== exp_out || done0 !== exp_done || busy0 !== ~exp_done) begin
                n_bad++;
                $display("FAIL soft_mask S+%0d: rst_out=%b done=%b busy=%b, expected %b/%b/%b",
                         n, rst_out0, done0, busy0, exp_out, exp_done, ~exp_done);
            end
        end
    endtask

    task automatic test_busy_request();
        int rel[4] = '{10, 13, 16, 19};
        logic [3:0] exp_out;
        logic       exp_done;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        step();
        step();
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) step();
            // Request sampled at E0+12 with an all-ones mask must have no effect.
            if (n == 11) begin
                soft0 = 1'b1;
                mask0 = 4'b1111;
            end else begin
                soft0 = 1'b0;
                mask0 = 4'b0000;
            end
            for (int i = 0; i < 4; i++) exp_out[i] = (n < rel[i]);
            exp_done = (n >= 19);
            n_cmp++;
            if (rst_out0 !== exp_out || done0 !== exp_done || busy0 !== ~exp_done) begin
                n_bad++;
                $display("FAIL busy_request E0+%0d: rst_out=%b done=%b busy=%b, expected %b/%b/%b",
                         n, rst_out0, done0, busy0, exp_out, exp_done, ~exp_done);
            end
        end
    endtask

    task automatic test_mid_reset();
        int rel[4] = '{10, 13, 16, 19};
        logic [3:0] exp_out;
        logic       exp_done;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        step();
        step();
        repeat (14) step();
        n_cmp++;
        if (rst_out0 !== 4'b1100 || done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_pre: rst_out=%b done=%b, expected 1100/0", rst_out0, done0);
        end
        rst0 = 1'b0;
        #1;
        n_cmp++;
        if (rst_out0 !== 4'b1111 || done0 !== 1'b0 || busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_async: rst_out=%b done=%b busy=%b, expected 1111/0/1",
                     rst_out0, done0, busy0);
        end
        #39;
        rst0 = 1'b1;
        step();
        step();
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) step();
            for (int i = 0; i < 4; i++) exp_out[i] = (n < rel[i]);
            exp_done = (n >= 19);
            n_cmp++;
            if (rst_out0 !== exp_out || done0 !== exp_done || busy0 !== ~exp_done) begin
                n_bad++;
                $display("FAIL mid_reset_replay E0+%0d: rst_out=%b done=%b busy=%b, expected %b/%b/%b",
                         n, rst_out0, done0, busy0, exp_out, exp_done, ~exp_done);
            end
        end
    endtask

    task automatic test_glitch();
        int edges = 0;
        #3;
        rst0 = 1'b0;
        #2;
        rst0 = 1'b1;
        #1;
        n_cmp++;
        if (rst_out0 !== 4'b1111 || done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_async: rst_out=%b done=%b, expected 1111/0", rst_out0, done0);
        end
        while (done0 !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        n_cmp++;
        if (edges != 21 || rst_out0 !== 4'b0000) begin
            n_bad++;
            $display("FAIL glitch_replay: edges_to_done=%0d rst_out=%b, expected 21/0000",
                     edges, rst_out0);
        end
    endtask

    task automatic test_single_channel();
        @(negedge clk);
        rst1 = 1'b1;
        step();
        step();
        n_cmp++;
        if (rst_out1 !== 1'b1 || done1 !== 1'b0 || busy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL single_E0: rst_out=%b done=%b busy=%b, expected 1/0/1",
                     rst_out1, done1, busy1);
        end
        step();
        n_cmp++;
        if (rst_out1 !== 1'b0 || done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_E0+1: rst_out=%b done=%b busy=%b, expected 0/1/0",
                     rst_out1, done1, busy1);
        end
        soft1 = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            step();
            n_cmp++;
            if (rst_out1 !== (n == 0 ? 1'b1 : 1'b0) || done1 !== (n == 0 ? 1'b0 : 1'b1)) begin
                n_bad++;
                $display("FAIL single_held_req S+%0d: rst_out=%b done=%b, expected %b/%b",
                         n, rst_out1, done1, (n == 0), (n != 0));
            end
        end
        soft1 = 1'b0;
        step();
        soft1 = 1'b1;
        step();
        n_cmp++;
        if (rst_out1 !== 1'b1 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rerise: rst_out=%b done=%b, expected 1/0", rst_out1, done1);
        end
        soft1 = 1'b0;
        step();
        n_cmp++;
        if (rst_out1 !== 1'b0 || done1 !== 1'b1) begin
            n_bad++;
            $display("FAIL single_rerise_done: rst_out=%b done=%b, expected 0/1", rst_out1, done1);
        end
    endtask

    task automatic test_eight_channels();
        logic [7:0] exp_out;
        logic       exp_done;
        @(negedge clk);
        rst2 = 1'b1;
        step();
        step();
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) step();
            for (int i = 0; i < 8; i++) exp_out[i] = (n < 10 + i);
            exp_done = (n >= 17);
            n_cmp++;
            if (rst_out2 !== exp_out || done2 !== exp_done || busy2 !== ~exp_done) begin
                n_bad++;
                $display("FAIL eight_ch E0+%0d: rst_out=%b done=%b busy=%b, expected %b/%b/%b",
                         n, rst_out2, done2, busy2, exp_out, exp_done, ~exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_mask();
        test_busy_request();
        test_mid_reset();
        test_glitch();
        test_single_channel();
        test_eight_channels();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
